// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - sequenced registered ALU front-end with button-driven A -> B -> OP loading
// Results and flags are registered only on leaving EXEC; zero/neg are taken from that same result.
module alu_seq_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sw,
  input  logic              btnA,
  input  logic              btnB,
  input  logic              btnOP,
  output logic [DATA_W-1:0] res_alu,
  output logic              carry,
  output logic              zero,
  output logic              neg,
  output logic              ovf,
  output logic              err,
  output logic              valid,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_WAIT_OP = 3'd2,
    S_EXEC    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [DATA_W-1:0] LP_W = DATA_W'(DATA_W);

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_sync_a, r_sync_b, r_sync_op;
  logic              w_pulse_a, w_pulse_b, w_pulse_op;
  logic              w_load_a, w_load_b, w_load_op, w_exec;
  logic [DATA_W-1:0] r_a, r_b, r_res;
  logic [5:0]        r_op;
  logic              r_carry, r_zero, r_neg, r_ovf, r_err, r_valid;
  logic [DATA_W:0]   w_sum, w_diff;
  logic [DATA_W-1:0] w_res;
  logic              w_carry, w_ovf, w_illegal;

  // bit0/bit1 synchronise, bit2 remembers the previous synchronised level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_a  <= 3'b000;
      r_sync_b  <= 3'b000;
      r_sync_op <= 3'b000;
    end else begin
      r_sync_a  <= {r_sync_a[1:0], btnA};
      r_sync_b  <= {r_sync_b[1:0], btnB};
      r_sync_op <= {r_sync_op[1:0], btnOP};
    end
  end

  assign w_pulse_a  = r_sync_a[1] & ~r_sync_a[2];
  assign w_pulse_b  = r_sync_b[1] & ~r_sync_b[2];
  assign w_pulse_op = r_sync_op[1] & ~r_sync_op[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_WAIT_A;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load_a  = 1'b0;
    w_load_b  = 1'b0;
    w_load_op = 1'b0;
    w_exec    = 1'b0;
    case (r_state)
      S_WAIT_A, S_DONE: if (w_pulse_a) begin
        w_load_a = 1'b1;
        w_next   = S_WAIT_B;
      end
      S_WAIT_B: if (w_pulse_b) begin
        w_load_b = 1'b1;
        w_next   = S_WAIT_OP;
      end
      S_WAIT_OP: if (w_pulse_op) begin
        w_load_op = 1'b1;
        w_next    = S_EXEC;
      end
      S_EXEC: begin
        w_exec = 1'b1;
        w_next = S_DONE;
      end
      default: w_next = S_WAIT_A;
    endcase
  end

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_res     = '0;
    w_carry   = 1'b0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res   = w_sum[DATA_W-1:0];
        w_carry = w_sum[DATA_W];
        w_ovf   = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_sum[DATA_W-1] != r_a[DATA_W-1]);
      end
      OP_SUB: begin
        w_res   = w_diff[DATA_W-1:0];
        w_carry = w_diff[DATA_W];
        w_ovf   = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_diff[DATA_W-1] != r_a[DATA_W-1]);
      end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOR: w_res = ~(r_a | r_b);
      OP_SRA: begin
        if (r_b >= LP_W) w_res = {DATA_W{r_a[DATA_W-1]}};
        else             w_res = $signed(r_a) >>> r_b;
      end
      OP_SRL: begin
        if (r_b >= LP_W) w_res = '0;
        else             w_res = r_a >> r_b;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_neg   <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_exec;
      if (w_load_a) begin
        r_a   <= sw;
        r_err <= 1'b0;
      end
      if (w_load_b)  r_b  <= sw;
      if (w_load_op) r_op <= sw[5:0];
      if (w_exec) begin
        r_res   <= w_res;
        r_carry <= w_carry;
        r_ovf   <= w_ovf;
        r_zero  <= (w_res == '0);
        r_neg   <= w_res[DATA_W-1];
        if (w_illegal) r_err <= 1'b1;
      end
    end
  end

  assign res_alu = r_res;
  assign carry   = r_carry;
  assign zero    = r_zero;
  assign neg     = r_neg;
  assign ovf     = r_ovf;
  assign err     = r_err;
  assign valid   = r_valid;
  assign state   = r_state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - table-driven and hand-sequenced checks for alu_seq_ctrl
module tb_alu_seq_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw;
  logic         btnA, btnB, btnOP;
  logic [W-1:0] res_alu;
  logic         carry, zero, neg, ovf, err, valid;
  logic [2:0]   state;

  int total = 0;
  int bad   = 0;
  int vcnt  = 0;
  int v0;
  logic [W-1:0] exp_prev;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [5:0]   op;
    logic [W-1:0] res;
    logic         c, z, n, v, e;
  } vec_t;

  vec_t vecs[18];

  alu_seq_ctrl #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .btnA(btnA), .btnB(btnB), .btnOP(btnOP),
    .res_alu(res_alu), .carry(carry), .zero(zero), .neg(neg),
    .ovf(ovf), .err(err), .valid(valid), .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid === 1'b1) vcnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // which: 0=A, 1=B, 2=OP, 3=A+B together; only the pressed buttons are touched
  task automatic press(input int which, input logic [W-1:0] v);
    @(negedge clk);
    sw = v;
    if (which == 0 || which == 3) btnA = 1'b1;
    if (which == 1 || which == 3) btnB = 1'b1;
    if (which == 2) btnOP = 1'b1;
    repeat (3) @(negedge clk);
    if (which == 0 || which == 3) btnA = 1'b0;
    if (which == 1 || which == 3) btnB = 1'b0;
    if (which == 2) btnOP = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_prev = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_res"},   32'(res_alu), 0);
    chk({tag, "_carry"}, 32'(carry), 0);
    chk({tag, "_zero"},  32'(zero), 0);
    chk({tag, "_neg"},   32'(neg), 0);
    chk({tag, "_ovf"},   32'(ovf), 0);
    chk({tag, "_err"},   32'(err), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_state"}, 32'(state), 0);
  endtask

  task automatic run_vec(input int i);
    int vb;
    vb = vcnt;
    press(0, vecs[i].a);
    press(1, vecs[i].b);
    chk($sformatf("v%0d_hold_res", i), 32'(res_alu), 32'(exp_prev));
    chk($sformatf("v%0d_err_clr", i), 32'(err), 0);
    press(2, {2'b00, vecs[i].op});
    chk($sformatf("v%0d_res", i),   32'(res_alu), 32'(vecs[i].res));
    chk($sformatf("v%0d_carry", i), 32'(carry), 32'(vecs[i].c));
    chk($sformatf("v%0d_zero", i),  32'(zero), 32'(vecs[i].z));
    chk($sformatf("v%0d_neg", i),   32'(neg), 32'(vecs[i].n));
    chk($sformatf("v%0d_ovf", i),   32'(ovf), 32'(vecs[i].v));
    chk($sformatf("v%0d_err", i),   32'(err), 32'(vecs[i].e));
    chk($sformatf("v%0d_state", i), 32'(state), 4);
    chk($sformatf("v%0d_vcnt", i),  32'(vcnt - vb), 1);
    exp_prev = vecs[i].res;
  endtask

  initial begin
    //              a      b      op        res    c     z     n     v     e
    vecs[0]  = '{8'hC8, 8'h64, 6'h20, 8'h2C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h50, 8'hB0, 6'h22, 8'hA0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{8'h7F, 8'h7F, 6'h22, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{8'h90, 8'h02, 6'h03, 8'hE4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'h90, 8'h02, 6'h02, 8'h24, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{8'h90, 8'h09, 6'h03, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'h90, 8'h09, 6'h02, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h90, 8'h02, 6'h27, 8'h6D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h7F, 8'h01, 6'h20, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{8'h00, 8'h01, 6'h22, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{8'hF0, 8'h3C, 6'h24, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{8'hF0, 8'h0F, 6'h25, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{8'hAA, 8'hAA, 6'h26, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{8'h40, 8'h03, 6'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{8'h80, 8'h08, 6'h03, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{8'h80, 8'h08, 6'h02, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{8'hFF, 8'h01, 6'h20, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{8'h3C, 8'h11, 6'h3F, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; sw = '0; btnA = 1'b0; btnB = 1'b0; btnOP = 1'b0;
    exp_prev = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // ADD with exact latency: OP raised before edge N, EXEC after N+2, valid only after N+3
    press(0, 8'hC8);
    press(1, 8'h64);
    v0 = vcnt;
    @(negedge clk);
    sw = 8'h20; btnOP = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat_exec_state", 32'(state), 3);
    chk("lat_exec_valid", 32'(valid), 0);
    @(negedge clk);
    chk("lat_valid_hi", 32'(valid), 1);
    chk("lat_state_done", 32'(state), 4);
    chk("lat_res", 32'(res_alu), 32'h2C);
    btnOP = 1'b0;
    @(negedge clk);
    chk("lat_valid_lo", 32'(valid), 0);
    repeat (2) @(negedge clk);
    chk("lat_vcnt", 32'(vcnt - v0), 1);
    exp_prev = 8'h2C;

    for (int i = 0; i < 18; i++) run_vec(i);

    // after the illegal op: an A load clears err, result is kept
    press(0, 8'h01);
    chk("ill_err_clr", 32'(err), 0);
    chk("ill_res_hold", 32'(res_alu), 0);
    chk("ill_zero_hold", 32'(zero), 1);
    chk("ill_state", 32'(state), 1);

    // ordering from WAIT_A
    do_reset();
    v0 = vcnt;
    press(1, 8'h12);
    chk("ord_b_state", 32'(state), 0);
    press(2, 8'h20);
    chk("ord_op_state", 32'(state), 0);
    chk("ord_res", 32'(res_alu), 0);
    chk("ord_vcnt", 32'(vcnt - v0), 0);
    press(3, 8'h11);
    chk("ord_ab_state", 32'(state), 1);
    press(1, 8'h22);
    chk("ord_b2_state", 32'(state), 2);
    press(2, 8'h20);
    chk("ord_add_res", 32'(res_alu), 32'h33);
    chk("ord_add_vcnt", 32'(vcnt - v0), 1);

    // A held ~50 cycles through a full sequence: DONE must not be left again
    @(negedge clk);
    sw = 8'h05; btnA = 1'b1;
    repeat (5) @(negedge clk);
    chk("hold_state_b", 32'(state), 1);
    press(1, 8'h06);
    press(2, 8'h20);
    chk("hold_res", 32'(res_alu), 32'h0B);
    chk("hold_state_done", 32'(state), 4);
    repeat (35) @(negedge clk);
    chk("hold_state_stay", 32'(state), 4);
    btnA = 1'b0;
    repeat (2) @(negedge clk);
    chk("hold_vcnt", 32'(vcnt - v0), 2);

    // async reset while in EXEC
    do_reset();
    run_vec(0);
    press(0, 8'h11);
    press(1, 8'h22);
    v0 = vcnt;
    @(negedge clk);
    sw = 8'h20; btnOP = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_exec_state", 32'(state), 3);
    #1 reset = 1'b1;
    #1 chk_all_zero("rst_exec");
    btnOP = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_exec_vcnt", 32'(vcnt - v0), 0);
    chk("rst_exec_state0", 32'(state), 0);
    exp_prev = '0;

    // async reset mid-cycle in DONE
    press(0, 8'h11);
    press(1, 8'h22);
    press(2, 8'h20);
    chk("rst_done_pre", 32'(res_alu), 32'h33);
    v0 = vcnt;
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("rst_done");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_done_vcnt", 32'(vcnt - v0), 0);
    exp_prev = '0;
    run_vec(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
